pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/ret_stack.sv | 50 +++++
 rtl/pc_ctrl.sv | 106 ++++++++++
 tb/tb_pc_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, return-stack depth, address type and
// the program-counter action encoding.
package cpu_pkg;

  localparam int unsigned PC_W        = 10;
  localparam int unsigned STACK_DEPTH = 8;

  typedef logic [PC_W-1:0] pc_t;

  // One action is applied per clock edge; listed from lowest to highest priority
  typedef enum logic [2:0] {
    ACT_INC    = 3'd0,
    ACT_BRANCH = 3'd1,
    ACT_CALL   = 3'd2,
    ACT_OVF    = 3'd3,
    ACT_RET    = 3'd4,
    ACT_UNF    = 3'd5,
    ACT_ILL    = 3'd6
  } act_e;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address store: array, occupancy pointer, full/empty flags,
// one write port and a combinational top-of-stack read port.
module ret_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  // Pointer counts occupied entries; the low bits index the next free slot
  assign wr_idx = ptr[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign top    = mem[rd_idx];
  assign full   = (ptr == PW'(DEPTH));
  assign empty  = (ptr == '0);

  // Occupancy pointer; overflowing pushes and underflowing pops leave it alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

  // Entry storage is not reset; contents are unobservable while empty
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: increment, branch, CALL and RET with a return
// stack. Optional sticky error flag enabled by PC_CTRL_STACK_ERR_EN.
module pc_ctrl #(
  parameter int unsigned PC_W        = cpu_pkg::PC_W,
  parameter int unsigned STACK_DEPTH = cpu_pkg::STACK_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_inc,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] jump_addr,
  output logic [PC_W-1:0] pc,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            stack_err
);

  cpu_pkg::act_e   act_c;
  logic [PC_W-1:0] pc_next_c;
  logic [PC_W-1:0] ret_addr_c;
  logic [PC_W-1:0] top_c;
  logic            wr_en_c;
  logic            rd_en_c;

  // Pick the single action for this cycle by priority
  always_comb begin
    act_c = cpu_pkg::ACT_INC;
    if (push && pop) begin
      act_c = cpu_pkg::ACT_ILL;
    end else if (pop) begin
      act_c = stack_empty ? cpu_pkg::ACT_UNF : cpu_pkg::ACT_RET;
    end else if (push) begin
      act_c = stack_full ? cpu_pkg::ACT_OVF : cpu_pkg::ACT_CALL;
    end else if (!s_inc) begin
      act_c = cpu_pkg::ACT_BRANCH;
    end
  end

  // Next pc and stack strobes for the selected action
  always_comb begin
    pc_next_c  = pc;
    wr_en_c    = 1'b0;
    rd_en_c    = 1'b0;
    ret_addr_c = pc + PC_W'(1);
    case (act_c)
      cpu_pkg::ACT_INC:    pc_next_c = pc + PC_W'(1);
      cpu_pkg::ACT_BRANCH: pc_next_c = jump_addr;
      cpu_pkg::ACT_CALL: begin
        pc_next_c = jump_addr;
        wr_en_c   = 1'b1;
      end
      cpu_pkg::ACT_OVF:    pc_next_c = jump_addr;
      cpu_pkg::ACT_RET: begin
        pc_next_c = top_c;
        rd_en_c   = 1'b1;
      end
      cpu_pkg::ACT_UNF:    pc_next_c = '0;
      cpu_pkg::ACT_ILL:    pc_next_c = pc;
      default:             pc_next_c = pc;
    endcase
  end

  // Program-counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else begin
      pc <= pc_next_c;
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_en_c),
    .pop     (rd_en_c),
    .wr_data (ret_addr_c),
    .top     (top_c),
    .full    (stack_full),
    .empty   (stack_empty)
  );

`ifdef PC_CTRL_STACK_ERR_EN
  logic err_set_c;

  assign err_set_c = (act_c == cpu_pkg::ACT_ILL) ||
                     (act_c == cpu_pkg::ACT_UNF) ||
                     (act_c == cpu_pkg::ACT_OVF);

  // Sticky error: set by illegal, underflow or overflow, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stack_err <= 1'b0;
    end else if (err_set_c) begin
      stack_err <= 1'b1;
    end
  end
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Testbench for pc_ctrl: directed scenarios followed by a random walk, all
// checked against a queue-based reference model.
module tb_pc_ctrl;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned DEPTH = 8;
  localparam int          MASK  = (1 << PC_W) - 1;

`ifdef PC_CTRL_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            s_inc = 1'b1;
  logic            push = 1'b0;
  logic            pop = 1'b0;
  logic [PC_W-1:0] jump_addr = '0;
  logic [PC_W-1:0] pc;
  logic            stack_full;
  logic            stack_empty;
  logic            stack_err;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int pc_m  = 0;
  int q[$];
  bit err_m = 1'b0;

  pc_ctrl #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_inc       (s_inc),
    .push        (push),
    .pop         (pop),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    32'(pc),          32'(pc_m));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(stack_full),  32'(q.size() == DEPTH));
    chk({tag, ".err"},   32'(stack_err),   32'(ERR_EN && err_m));
  endtask

  // Called at a falling edge: drive inputs, advance the model, check after the rising edge
  task automatic step(input bit si, input bit pu, input bit po, input int ja, input string tag);
    s_inc     = si;
    push      = pu;
    pop       = po;
    jump_addr = PC_W'(ja);
    if (pu && po) begin
      err_m = 1'b1;
    end else if (po) begin
      if (q.size() > 0) pc_m = q.pop_back();
      else begin
        pc_m  = 0;
        err_m = 1'b1;
      end
    end else if (pu) begin
      if (q.size() < DEPTH) q.push_back((pc_m + 1) & MASK);
      else err_m = 1'b1;
      pc_m = ja & MASK;
    end else if (!si) begin
      pc_m = ja & MASK;
    end else begin
      pc_m = (pc_m + 1) & MASK;
    end
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // Reset spanning one rising edge, released at a falling edge
  task automatic do_reset(input string tag);
    s_inc = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b0;
    q.delete();
    pc_m  = 0;
    err_m = 1'b0;
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int op;
    int ja;
    @(negedge clk);
    do_reset("por");

    // Five increments from reset
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, "inc");
    chk("inc5.pc", 32'(pc), 32'd5);

    // Branch at pc=3 then increment
    do_reset("rst_br");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "inc3");
    step(0, 0, 0, 'h40, "branch");
    chk("branch.pc", 32'(pc), 32'h40);
    step(1, 0, 0, 0, "after_br");
    chk("after_br.pc", 32'(pc), 32'h41);

    // Single CALL/RET
    step(0, 0, 0, 'h10, "to_10");
    step(1, 1, 0, 'h80, "call");
    chk("call.pc", 32'(pc), 32'h80);
    step(1, 0, 1, 0, "ret");
    chk("ret.pc", 32'(pc), 32'h11);

    // Fill, overflow, then drain in LIFO order
    for (int i = 0; i < 8; i++) step(0, 1, 0, 'h100 + 16 * i, "nest");
    chk("nest.full", 32'(stack_full), 32'd1);
    step(0, 1, 0, 'h200, "ovf");
    chk("ovf.pc", 32'(pc), 32'h200);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, "drain");
    chk("drain.pc", 32'(pc), 32'h12);

    // Underflow, illegal, stickiness
    step(1, 0, 1, 0, "unf");
    chk("unf.pc", 32'(pc), 32'h0);
    step(1, 0, 0, 0, "inc_u");
    step(1, 1, 1, 'h55, "illegal");
    chk("illegal.pc", 32'(pc), 32'h1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "sticky");

    // Wrap at the top of the address space
    step(0, 0, 0, 'h3FF, "to_3ff");
    step(1, 0, 0, 0, "wrap");
    chk("wrap.pc", 32'(pc), 32'h0);

    // Asynchronous reset between edges right after a push
    step(1, 1, 0, 'h2A0, "pre_rst_push");
    reset = 1'b0;
    q.delete();
    pc_m  = 0;
    err_m = 1'b0;
    #1;
    check_all("async_rst");
    chk("async_rst.empty", 32'(stack_empty), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 0, 0, "first_after_rst");

    // Random walk
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 99));
      ja = int'($urandom_range(0, MASK));
      if (op < 1) do_reset("rnd_rst");
      else if (op < 6) step(1'($urandom), 1, 1, ja, "rnd_ill");
      else if (op < 30) step(1'($urandom), 0, 1, ja, "rnd_pop");
      else if (op < 55) step(1'($urandom), 1, 0, ja, "rnd_push");
      else if (op < 70) step(0, 0, 0, ja, "rnd_br");
      else step(1, 0, 0, ja, "rnd_inc");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
